// File: rtl/count_track_pkg.sv
// Shared types and constants for the ripple-counter tracker.
// Imported by the stability filter and the tracker top.
package count_track_pkg;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } track_state_e;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_WRAP_W        = 8;
    localparam int RUN_W             = 4;
    localparam int DELTA_UP          = 1;

    // -1 modulo 2^w, i.e. the all-ones pattern of a w-bit bus
    function automatic int unsigned delta_dn(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_stable_filter.sv
// Two-flop synchronizer plus a run-length filter.
// Each value held stable long enough is accepted once.
module sync_stable_filter
    import count_track_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] qin,
    output logic [WIDTH-1:0] cand,
    output logic             accept
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [RUN_W-1:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= qin;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            run  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            run  <= RUN_W'(1);
        end else if (run != RUN_MAX) begin
            run <= run + RUN_W'(1);
        end
    end

    assign accept = (sync2 == cand) && (run == RUN_ACC);

endmodule

// File: rtl/updown_count_tracker.sv
// Tracks an asynchronous up/down ripple counter in the clk domain,
// reporting steps, terminal counts, wraps and direction/step errors.
module updown_count_tracker
    import count_track_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int WRAP_W        = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  qin,
    input  logic              mode,
    input  logic              clr,
    output logic [WIDTH-1:0]  count,
    output logic              valid,
    output logic              step,
    output logic              tc_up,
    output logic              tc_down,
    output logic              dir_err,
    output logic              step_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0] D_UP = WIDTH'(DELTA_UP);
    localparam logic [WIDTH-1:0] D_DN = WIDTH'(delta_dn(WIDTH));

    track_state_e     state_q;
    track_state_e     state_d;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] delta;
    logic             accept;
    logic             step_d;
    logic             tc_up_d;
    logic             tc_dn_d;
    logic             dir_d;
    logic             serr_d;

    sync_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .qin    (qin),
        .cand   (cand),
        .accept (accept)
    );

    assign delta = cand - count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACQ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = ACQ;
        else if (state_q == ACQ && accept)
            state_d = TRACK;
    end

    // clr discards a coincident accept, so it also blocks pulses
    always_comb begin
        step_d  = 1'b0;
        tc_up_d = 1'b0;
        tc_dn_d = 1'b0;
        dir_d   = 1'b0;
        serr_d  = 1'b0;
        if (state_q == TRACK && accept && !clr) begin
            unique case (1'b1)
                (delta == D_UP): begin
                    step_d  = 1'b1;
                    tc_up_d = (count == D_DN);
                    dir_d   = mode;
                end
                (delta == D_DN): begin
                    step_d  = 1'b1;
                    tc_dn_d = (count == '0);
                    dir_d   = !mode;
                end
                (delta == '0): begin
                end
                default: serr_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            valid    <= 1'b0;
            step     <= 1'b0;
            tc_up    <= 1'b0;
            tc_down  <= 1'b0;
            dir_err  <= 1'b0;
            step_err <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            step    <= step_d;
            tc_up   <= tc_up_d;
            tc_down <= tc_dn_d;
            if (clr) begin
                valid    <= 1'b0;
                dir_err  <= 1'b0;
                step_err <= 1'b0;
                wrap_cnt <= '0;
            end else begin
                if (accept) begin
                    count <= cand;
                    valid <= 1'b1;
                end
                if (dir_d)  dir_err  <= 1'b1;
                if (serr_d) step_err <= 1'b1;
                if ((tc_up_d || tc_dn_d) && wrap_cnt != '1)
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

endmodule
